// File: rtl/ntt_coef_loader.sv
// Serial-to-parallel coefficient loader for the 16-point NTT core.
// Reduces each beat modulo q on capture and presents whole, well-framed blocks only.
module ntt_coef_lane #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         ld,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)  q <= '0;
        else if (ld) q <= d;
    end
endmodule

module ntt_coef_loader #(
    parameter int N = 16,
    parameter int W = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [W-1:0]   q_in,
    input  logic [3:0]     w_in,
    input  logic           s_valid,
    output logic           s_ready,
    input  logic [W-1:0]   s_data,
    input  logic           s_last,
    output logic           blk_valid,
    input  logic           blk_ack,
    output logic [N*W-1:0] coef_flat,
    output logic [W-1:0]   q_out,
    output logic [3:0]     w_out,
    output logic           err,
    output logic [15:0]    blk_cnt
);
    localparam int IW = $clog2(N);
    localparam logic [0:0] FILL = 1'b0;
    localparam logic [0:0] FULL = 1'b1;

    logic [0:0]            state;
    logic [IW-1:0]         idx;
    logic                  bad;
    logic [N-1:0][W-1:0]   coef;

    logic                  beat, first, last_idx, frame_err, blk_end, bad_eff;
    logic [W-1:0]          q_eff, q_div, red;

    assign s_ready   = (state == FILL);
    assign blk_valid = (state == FULL);
    assign coef_flat = coef;

    assign beat      = s_valid && s_ready;
    assign first     = (idx == '0);
    assign last_idx  = (idx == IW'(N - 1));
    assign frame_err = beat && (s_last != last_idx);
    assign blk_end   = beat && (s_last || last_idx);

    // The first beat has no latched q yet, so it reduces against q_in directly.
    assign q_eff   = first ? q_in : q_out;
    assign bad_eff = first ? (q_in < W'(2)) : bad;
    assign q_div   = (q_eff < W'(2)) ? W'(1) : q_eff;
    assign red     = bad_eff ? '0 : (s_data % q_div);

    for (genvar k = 0; k < N; k++) begin : g_lane
        ntt_coef_lane #(.W(W)) u_lane (
            .clk   (clk),
            .rst_n (rst_n),
            .ld    (beat && (idx == IW'(k))),
            .d     (red),
            .q     (coef[k])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= FILL;
            idx     <= '0;
            bad     <= 1'b0;
            q_out   <= '0;
            w_out   <= '0;
            err     <= 1'b0;
            blk_cnt <= '0;
        end else begin
            err <= 1'b0;
            if (beat) begin
                if (first) begin
                    q_out <= q_in;
                    w_out <= w_in;
                    bad   <= bad_eff;
                end
                if (blk_end) begin
                    idx <= '0;
                    bad <= 1'b0;
                    if (frame_err || bad_eff) err   <= 1'b1;
                    else                      state <= FULL;
                end else begin
                    idx <= idx + 1'b1;
                end
            end
            if (state == FULL && blk_ack) begin
                state   <= FILL;
                idx     <= '0;
                blk_cnt <= blk_cnt + 16'd1;
            end
        end
    end
endmodule
